writeback_unit: RTL

Write-side driver for the CPU register file. It accepts result packets from the ALU and the load/store unit over valid/ready handshakes and arbitrates between them round-robin. Accepted results are queued in a small in-order FIFO and drained one per cycle onto the register file's `writeEn`/`writeSel`/`writeData` port. An optional query port lets hazard logic see results that are queued but not yet committed.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_fifo.sv | 107 ++++++++++
 rtl/writeback_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback path.
//   wb_src_e   : identifies which producer (ALU or LSU) owns a grant.
//   wb_entry_t : one queued result {rd, data} at the default widths.
package wb_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] rd;
        logic [DEFAULT_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order result FIFO for the writeback unit.
// Build option: WB_QUERY_EN builds the rd compare used by hazard logic;
// without it query_hit_o/query_data_o are tied to zero.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i/push_rd_i/push_data_i   enqueue one entry (ignored when full)
//   pop_i             dequeue the head entry (ignored when empty)
//   head_rd_o/head_data_o          oldest entry
//   full_o/empty_o/count_o         occupancy status (from registered pointers)
//   query_rd_i/query_hit_o/query_data_o   youngest matching queued entry
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [ADDR_W-1:0]            push_rd_i,
    input  logic [DATA_W-1:0]            push_data_i,
    input  logic                         pop_i,
    output logic [ADDR_W-1:0]            head_rd_o,
    output logic [DATA_W-1:0]            head_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    input  logic [ADDR_W-1:0]            query_rd_i,
    output logic                         query_hit_o,
    output logic [DATA_W-1:0]            query_data_o
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    // Index bits plus one wrap bit distinguish full from empty.
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW-1:0] used;
    logic            do_push;
    logic            do_pop;

    assign used    = wptr_q - rptr_q;
    assign count_o = CntW'(used);
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]) &&
                     (wptr_q[IdxW] != rptr_q[IdxW]);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign head_rd_o   = rd_q[rptr_q[IdxW-1:0]];
    assign head_data_o = data_q[rptr_q[IdxW-1:0]];

    always_comb begin
        wptr_d = wptr_q + PtrW'(do_push);
        rptr_d = rptr_q + PtrW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_q[wptr_q[IdxW-1:0]]   <= push_rd_i;
            data_q[wptr_q[IdxW-1:0]] <= push_data_i;
        end
    end

`ifdef WB_QUERY_EN
    logic [IdxW-1:0] q_idx;

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        query_hit_o  = 1'b0;
        query_data_o = '0;
        q_idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            q_idx = rptr_q[IdxW-1:0] + IdxW'(i);
            if ((PtrW'(i) < used) && (query_rd_i != '0) && (rd_q[q_idx] == query_rd_i)) begin
                query_hit_o  = 1'b1;
                query_data_o = data_q[q_idx];
            end
        end
    end
`else
    logic unused_query_rd;

    assign unused_query_rd = ^query_rd_i;
    assign query_hit_o     = 1'b0;
    assign query_data_o    = '0;
`endif

endmodule

// File: rtl/writeback_unit.sv
// Register-file write driver: round-robin arbitration between ALU and LSU
// results, x0 filtering, an in-order FIFO, and one commit per cycle.
// Build option: WB_QUERY_EN enables the queued-result query compare.
// Ports:
//   clk, rst_n                               clock, asynchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data      ALU result handshake
//   lsu_valid/lsu_ready/lsu_rd/lsu_data      load result handshake
//   wb_stall                                 holds off register-file writes
//   writeEn/writeSel/writeData               register-file write port
//   count                                    FIFO occupancy
//   query_rd/query_hit/query_data            hazard probe of queued results
module writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [ADDR_W-1:0]            alu_rd,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [ADDR_W-1:0]            lsu_rd,
    input  logic [DATA_W-1:0]            lsu_data,
    input  logic                         wb_stall,
    output logic                         writeEn,
    output logic [ADDR_W-1:0]            writeSel,
    output logic [DATA_W-1:0]            writeData,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic [ADDR_W-1:0]            query_rd,
    output logic                         query_hit,
    output logic [DATA_W-1:0]            query_data
);

    wb_src_e           last_q, last_d;
    logic              full, empty;
    logic              grant_alu, grant_lsu;
    logic              accept, push, pop;
    logic [ADDR_W-1:0] sel_rd, head_rd;
    logic [DATA_W-1:0] sel_data, head_data;

    always_comb begin
        // Tie goes to whichever source was not granted last time.
        grant_alu = alu_valid && (!lsu_valid || (last_q == SRC_LSU));
        grant_lsu = lsu_valid && !grant_alu;

        // Full comes from registered pointers, so a same-cycle pop cannot open ready.
        alu_ready = !full && grant_alu;
        lsu_ready = !full && grant_lsu;
        accept    = (alu_valid && alu_ready) || (lsu_valid && lsu_ready);

        sel_rd   = grant_alu ? alu_rd : lsu_rd;
        sel_data = grant_alu ? alu_data : lsu_data;

        // x0 writes complete the handshake but are never queued.
        push = accept && (sel_rd != '0);

        last_d = last_q;
        if (accept) begin
            last_d = grant_alu ? SRC_ALU : SRC_LSU;
        end

        pop       = !empty && !wb_stall;
        writeEn   = pop;
        writeSel  = pop ? head_rd : '0;
        writeData = pop ? head_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= SRC_LSU;
        end else begin
            last_q <= last_d;
        end
    end

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_rd_i    (sel_rd),
        .push_data_i  (sel_data),
        .pop_i        (pop),
        .head_rd_o    (head_rd),
        .head_data_o  (head_data),
        .full_o       (full),
        .empty_o      (empty),
        .count_o      (count),
        .query_rd_i   (query_rd),
        .query_hit_o  (query_hit),
        .query_data_o (query_data)
    );

endmodule
